// File: rtl/rs170_video_timing_gen.sv
// RS-170 interlaced timing generator: free-running raster counters plus an AXI4-Stream
// pixel sink that locks the incoming video to the field-0 start and flags stream faults.
module rs170_video_timing_gen #(
    parameter int AXIS_DATA_WIDTH = 16,
    parameter int H_ACTIVE        = 720,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 62,
    parameter int H_BP            = 60,
    parameter int V_ACTIVE        = 240,
    parameter int V_FP            = 3,
    parameter int V_SYNC          = 3,
    parameter int V_BP            = 16
) (
    input  logic                       i_pclk,
    input  logic                       i_rstn,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tuser,
    input  logic                       s_axis_tlast,
    output logic                       o_vsync,
    output logic                       o_hsync,
    output logic                       o_blank,
    output logic                       o_field,
    output logic [AXIS_DATA_WIDTH-1:0] o_data,
    output logic                       o_locked,
    output logic                       o_underflow
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL0 = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_TOTAL1 = V_TOTAL0 + 1;
    localparam int H_W      = $clog2(H_TOTAL);
    localparam int V_W      = $clog2(V_TOTAL1);

    typedef enum logic [1:0] {
        WAIT_SOF,
        ARMED,
        RUN
    } state_t;

    logic           rst_sync_n;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           field;
    state_t         state;
    state_t         state_nxt;
    logic           err_pend;
    logic           err_pend_nxt;

    logic last_h, last_v, field_wrap, frame_wrap;
    logic active, hsync_pos, vsync_pos, sof_pos, eol_pos;
    logic take, err_now;

    // Reset asserts asynchronously; its release is retimed to i_pclk so every
    // downstream register leaves reset on the same edge.
    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) rst_sync_n <= 1'b0;
        else         rst_sync_n <= 1'b1;
    end

    assign last_h     = (h_cnt == H_W'(H_TOTAL - 1));
    assign last_v     = field ? (v_cnt == V_W'(V_TOTAL1 - 1)) : (v_cnt == V_W'(V_TOTAL0 - 1));
    assign field_wrap = last_h && last_v;
    assign frame_wrap = field_wrap && field;

    assign active    = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
    assign hsync_pos = (h_cnt >= H_W'(H_ACTIVE + H_FP)) && (h_cnt < H_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_pos = (v_cnt >= V_W'(V_ACTIVE + V_FP)) && (v_cnt < V_W'(V_ACTIVE + V_FP + V_SYNC));
    assign sof_pos   = (h_cnt == '0) && (v_cnt == '0);
    assign eol_pos   = (h_cnt == H_W'(H_ACTIVE - 1));

    assign take    = (state == RUN) && active && s_axis_tvalid;
    assign err_now = (state == RUN) && active &&
                     (!s_axis_tvalid || (s_axis_tuser && !sof_pos) || (s_axis_tlast != eol_pos));

    always_ff @(posedge i_pclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
            field <= 1'b0;
        end else if (last_h) begin
            h_cnt <= '0;
            if (last_v) begin
                v_cnt <= '0;
                field <= ~field;
            end else begin
                v_cnt <= v_cnt + V_W'(1);
            end
        end else begin
            h_cnt <= h_cnt + H_W'(1);
        end
    end

    always_ff @(posedge i_pclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= WAIT_SOF;
            err_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            err_pend <= err_pend_nxt;
        end
    end

    // A faulted field keeps its timing and data to the end; resync happens at the wrap.
    always_comb begin
        state_nxt    = state;
        err_pend_nxt = err_pend;
        case (state)
            WAIT_SOF: if (s_axis_tvalid && s_axis_tuser) state_nxt = ARMED;
            ARMED:    if (frame_wrap) state_nxt = RUN;
            RUN: begin
                err_pend_nxt = err_pend || err_now;
                if (err_pend && field_wrap) begin
                    state_nxt    = WAIT_SOF;
                    err_pend_nxt = 1'b0;
                end
            end
            default:  state_nxt = WAIT_SOF;
        endcase
    end

    // In WAIT_SOF the SOF pixel is refused so it is still on the bus when RUN begins.
    always_comb begin
        s_axis_tready = 1'b0;
        if (rst_sync_n) begin
            case (state)
                WAIT_SOF: s_axis_tready = !(s_axis_tvalid && s_axis_tuser);
                RUN:      s_axis_tready = active;
                default:  s_axis_tready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_pclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            o_vsync     <= 1'b0;
            o_hsync     <= 1'b0;
            o_blank     <= 1'b1;
            o_field     <= 1'b0;
            o_data      <= '0;
            o_locked    <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_vsync     <= vsync_pos;
            o_hsync     <= hsync_pos;
            o_blank     <= !active;
            o_field     <= field;
            o_data      <= take ? s_axis_tdata : '0;
            o_locked    <= (state == RUN);
            o_underflow <= o_underflow || err_now;
        end
    end

endmodule

// File: doc/rs170_video_timing_gen.md
RS170_VIDEO_TIMING_GEN -- requirements
Module: rs170_video_timing_gen

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 16, giving the pixel data width.
REQ-002 SHALL have parameters H_ACTIVE 720, H_FP 16, H_SYNC 62, H_BP 60, giving pixels per line region; H_TOTAL = sum.
REQ-003 SHALL have parameters V_ACTIVE 240, V_FP 3, V_SYNC 3, V_BP 16, giving lines per field region; field 1 has V_BP+1 back-porch lines.
REQ-004 SHALL have ports:
  i_pclk  in  1  pixel clock, all logic rising-edge;
  i_rstn  in  1  asynchronous active-low reset;
  s_axis_tdata  in  AXIS_DATA_WIDTH  pixel;
  s_axis_tvalid  in  1  pixel valid;
  s_axis_tready  out  1  pixel accepted when tvalid&tready;
  s_axis_tuser  in  1  first pixel of a field;
  s_axis_tlast  in  1  last pixel of a line;
  o_vsync  out  1  vertical sync, active-high;
  o_hsync  out  1  horizontal sync, active-high;
  o_blank  out  1  high outside active region;
  o_field  out  1  current field, 0 or 1;
  o_data  out  AXIS_DATA_WIDTH  pixel, zero when blanked;
  o_locked  out  1  state is RUN;
  o_underflow  out  1  sticky underflow/framing error.

Function
REQ-005 SHALL run h_cnt 0..H_TOTAL-1, wrapping to 0 and advancing v_cnt; counters SHALL free-run from reset regardless of stream state.
REQ-006 SHALL run v_cnt 0..(field line count)-1; wrap SHALL toggle field; field 0 = V_ACTIVE+V_FP+V_SYNC+V_BP lines, field 1 = one more.
REQ-007 SHALL define the active region as h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-008 SHALL define hsync as H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-009 SHALL define vsync as V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for all pixels of those lines.
REQ-010 SHALL register all o_* outputs; each SHALL reflect counter position (h,v) exactly one cycle after the counters hold (h,v).
REQ-011 SHALL implement a state machine with states WAIT_SOF, ARMED and RUN.
REQ-012 WAIT_SOF: tready=1 and pixels are discarded until tvalid&tuser; on that cycle tready=0 and state goes to ARMED, so the SOF pixel is not consumed.
REQ-013 ARMED: tready=0; state SHALL go to RUN on the cycle counters reach field 0, v=0, h=0.
REQ-014 RUN: tready SHALL equal the active-region flag; o_data SHALL be tdata when tvalid in an active cycle, and otherwise 0.
REQ-015 RUN, active cycle with tvalid=0: underflow; o_data=0, o_underflow set, counters unaffected.
REQ-016 RUN, accepted pixel with tuser=1 at other than (v=0,h=0), or tlast value not equal to (h_cnt==H_ACTIVE-1): framing error, o_underflow set.
REQ-017 On any error in RUN the state SHALL go to WAIT_SOF at the next field wrap; until then output timing SHALL continue and accepted data SHALL be output.
REQ-018 The next field's tuser pixel SHALL be accepted at (v=0,h=0) of each field in RUN; field alternation SHALL be assumed in stream order.
REQ-019 o_underflow SHALL clear only on reset; o_locked SHALL be high exactly when state is RUN.
REQ-020 Blanking: o_data SHALL be 0 and o_blank 1 for every non-active position in any state.

Reset
REQ-021 While i_rstn=0: h_cnt=0, v_cnt=0, field=0, state WAIT_SOF, tready=0, o_vsync=0, o_hsync=0, o_blank=1, o_field=0, o_data=0, o_locked=0, o_underflow=0.
REQ-022 Reset assertion mid-field SHALL take effect asynchronously; deassertion SHALL be synchronised to i_pclk; counting SHALL resume from (0,0,field 0) on the first clock edge after deassertion.

Verification (H_ACTIVE 8, H_FP 2, H_SYNC 2, H_BP 2, V_ACTIVE 4, V_FP 1, V_SYNC 1, V_BP 1)
REQ-023 No stream, run 2 fields -> H_TOTAL 14; field 0 = 7 lines = 98 cycles; field 1 = 8 lines = 112 cycles; hsync high for h 10..11; vsync on line 5; o_field toggles; o_locked=0.
REQ-024 Continuous valid stream, tuser on first pixel, pixels 0x0000,0x0001,... -> lock at field 0 start; o_data sequence matches one cycle after acceptance; 32 pixels per field; o_underflow=0.
REQ-025 Drop tvalid for one active cycle in field 0 line 2 -> o_data=0 that position; o_underflow=1; WAIT_SOF after field wrap; relock at next field 0.
REQ-026 tlast missing on a line's 8th pixel -> o_underflow=1; o_locked falls at field wrap.
REQ-027 3 junk pixels before tuser while in WAIT_SOF -> junk dropped (tready=1), tuser pixel held (tready=0), first o_data pixel = tuser pixel.
REQ-028 Assert i_rstn=0 mid-line in RUN -> all outputs take reset values immediately; after release, timing restarts at (0,0) and relock requires new tuser.
